// File: rtl/decode_stage.sv
// decode_stage: 2-entry instruction buffer between fetch and rename with a
// combinational RV32I field/immediate/control decoder on the head entry.
module decode_stage #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  T           instr_from_fetch,
    input  T           pc_from_fetch,
    input  logic       valid_in,
    output logic       ready_to_fetch,
    input  logic       flush,
    input  logic       ready_in,
    output logic       valid_out,
    output T           pc_out,
    output logic [4:0] rs1,
    output logic [4:0] rs2,
    output logic [4:0] rd,
    output logic [6:0] opcode,
    output logic [2:0] funct3,
    output logic [6:0] funct7,
    output T           imm,
    output logic       reg_write,
    output logic       is_branch,
    output logic       is_load,
    output logic       is_store,
    output logic       alu_src_imm,
    output logic       illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [1:0] count_q, count_d;
    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    T           buf_instr_q [DEPTH];
    T           buf_instr_d [DEPTH];
    T           buf_pc_q    [DEPTH];
    T           buf_pc_d    [DEPTH];

    logic push, pop;
    T     head;

    // Handshake status comes from registered count only, so ready_in never
    // reaches ready_to_fetch combinationally.
    assign ready_to_fetch = (count_q < 2'(DEPTH));
    assign valid_out      = (count_q != 2'd0);
    assign push           = valid_in && ready_to_fetch && !flush;
    assign pop            = valid_out && ready_in && !flush;

    // Next-state for FIFO bookkeeping and storage; flush empties the buffer
    // and drops any same-edge transfer.
    always_comb begin
        count_d     = count_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        if (flush) begin
            count_d = 2'd0;
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
        end else begin
            if (push) begin
                buf_instr_d[wptr_q] = instr_from_fetch;
                buf_pc_d[wptr_q]    = pc_from_fetch;
                wptr_d              = ~wptr_q;
            end
            if (pop) begin
                rptr_d = ~rptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Control state; reset wins over flush and both transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // Buffer payload needs no reset; count gates its visibility.
    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc_q    <= buf_pc_d;
    end

    assign head   = buf_instr_q[rptr_q];
    assign pc_out = buf_pc_q[rptr_q];
    assign opcode = head[6:0];
    assign rd     = head[11:7];
    assign funct3 = head[14:12];
    assign rs1    = head[19:15];
    assign rs2    = head[24:20];
    assign funct7 = head[31:25];

    logic wr_cls, br, ld, st, alu, ill;

    // Classify the head opcode and build the immediate; flags are forced
    // low whenever no entry is presented.
    always_comb begin
        imm    = '0;
        wr_cls = 1'b0;
        br     = 1'b0;
        ld     = 1'b0;
        st     = 1'b0;
        alu    = 1'b0;
        ill    = 1'b0;
        case (head[6:0])
            OP_LUI, OP_AUIPC: begin
                imm    = {head[31:12], 12'b0};
                wr_cls = 1'b1;
                alu    = 1'b1;
            end
            OP_JAL: begin
                imm    = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
                wr_cls = 1'b1;
                br     = 1'b1;
                alu    = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_OPIMM: begin
                imm    = {{20{head[31]}}, head[31:20]};
                wr_cls = 1'b1;
                alu    = 1'b1;
                br     = (head[6:0] == OP_JALR);
                ld     = (head[6:0] == OP_LOAD);
            end
            OP_STORE: begin
                imm = {{20{head[31]}}, head[31:25], head[11:7]};
                st  = 1'b1;
                alu = 1'b1;
            end
            OP_BRANCH: begin
                imm = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
                br  = 1'b1;
            end
            OP_OP: begin
                wr_cls = 1'b1;
            end
            default: begin
                ill = 1'b1;
            end
        endcase
        reg_write   = valid_out && wr_cls && (head[11:7] != 5'd0);
        is_branch   = valid_out && br;
        is_load     = valid_out && ld;
        is_store    = valid_out && st;
        alu_src_imm = valid_out && alu;
        illegal     = valid_out && ill;
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed decode table, handshake corner sequences and a
// randomized run against a queue-based reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, valid_in, flush, ready_in;
    logic [31:0] instr_from_fetch, pc_from_fetch;
    logic        ready_to_fetch, valid_out;
    logic [31:0] pc_out, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        reg_write, is_branch, is_load, is_store, alu_src_imm, illegal;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset),
        .instr_from_fetch(instr_from_fetch), .pc_from_fetch(pc_from_fetch),
        .valid_in(valid_in), .ready_to_fetch(ready_to_fetch),
        .flush(flush), .ready_in(ready_in),
        .valid_out(valid_out), .pc_out(pc_out),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .imm(imm),
        .reg_write(reg_write), .is_branch(is_branch), .is_load(is_load),
        .is_store(is_store), .alu_src_imm(alu_src_imm), .illegal(illegal)
    );

    // flags packed as {reg_write, is_branch, is_load, is_store, alu_src_imm, illegal}
    logic [5:0] fl_act;
    assign fl_act = {reg_write, is_branch, is_load, is_store, alu_src_imm, illegal};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t mq[$];

    typedef struct packed {
        logic [4:0]  rd, rs1, rs2;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [5:0]  fl;
    } dec_t;

    function automatic logic [31:0] sra(input logic [31:0] v, input int sh);
        return 32'($signed(v) >>> sh);
    endfunction

    function automatic dec_t ref_dec(input logic [31:0] i);
        dec_t d;
        byte  fmt;
        logic wr;
        d.rd = i[11:7]; d.rs1 = i[19:15]; d.rs2 = i[24:20];
        d.op = i[6:0];  d.f3 = i[14:12];  d.f7 = i[31:25];
        d.fl = '0;
        wr   = 1'b0;
        case (i[6:0])
            7'b0110111, 7'b0010111: fmt = "U";
            7'b1101111:             fmt = "J";
            7'b1100111, 7'b0000011, 7'b0010011: fmt = "I";
            7'b0100011:             fmt = "S";
            7'b1100011:             fmt = "B";
            7'b0110011:             fmt = "R";
            default:                fmt = "X";
        endcase
        case (fmt)
            "I": d.imm = sra(i, 20);
            "S": d.imm = sra({i[31:25], i[11:7], 20'b0}, 20);
            "B": d.imm = sra({i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0}, 19);
            "U": d.imm = i & 32'hFFFF_F000;
            "J": d.imm = sra({i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0}, 11);
            default: d.imm = 32'd0;
        endcase
        wr = (fmt inside {"U", "J", "I", "R"}) && (i[11:7] != 5'd0);
        d.fl[5] = wr;
        d.fl[4] = (i[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111});
        d.fl[3] = (i[6:0] == 7'b0000011);
        d.fl[2] = (i[6:0] == 7'b0100011);
        d.fl[1] = (fmt != "R") && (fmt != "B") && (fmt != "X");
        d.fl[0] = (fmt == "X");
        return d;
    endfunction

    // One clock: model advances on the same edge using pre-edge state.
    task automatic tick();
        bit rdy, vout;
        @(posedge clk);
        rdy  = (mq.size() < 2);
        vout = (mq.size() != 0);
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (vout && ready_in) void'(mq.pop_front());
            if (valid_in && rdy) mq.push_back('{instr_from_fetch, pc_from_fetch});
        end
        #1;
    endtask

    task automatic chk_state(input string nm);
        dec_t a, e;
        chk({nm, "_hs"}, {126'd0, valid_out, ready_to_fetch},
            {126'd0, mq.size() != 0, mq.size() < 2});
        if (mq.size() != 0) begin
            a = '{rd, rs1, rs2, opcode, funct7, funct3, imm, fl_act};
            e = ref_dec(mq[0].instr);
            chk({nm, "_pc"}, pc_out, mq[0].pc);
            chk({nm, "_dec"}, a, e);
        end else begin
            chk({nm, "_flags0"}, fl_act, 6'd0);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] instr, pc;
        logic [4:0]  rd, rs1;
        logic [31:0] imm;
        logic [5:0]  fl;
    } vec_t;
    vec_t tbl[9];

    logic [6:0] ops[9];

    initial begin
        tbl[0] = '{32'h00500093, 32'h00, 5'd1,  5'd0,  32'h00000005, 6'b100010}; // addi x1,x0,5
        tbl[1] = '{32'hFE208EE3, 32'h40, 5'd29, 5'd1,  32'hFFFFFFFC, 6'b010000}; // beq x1,x2,-4
        tbl[2] = '{32'h0020A423, 32'h44, 5'd8,  5'd1,  32'h00000008, 6'b000110}; // sw x2,8(x1)
        tbl[3] = '{32'h123452B7, 32'h48, 5'd5,  5'd8,  32'h12345000, 6'b100010}; // lui x5
        tbl[4] = '{32'hFFFFFFFF, 32'h4C, 5'd31, 5'd31, 32'h00000000, 6'b000001}; // illegal
        tbl[5] = '{32'h002081B3, 32'h50, 5'd3,  5'd1,  32'h00000000, 6'b100000}; // add x3,x1,x2
        tbl[6] = '{32'hFF812303, 32'h54, 5'd6,  5'd2,  32'hFFFFFFF8, 6'b101010}; // lw x6,-8(x2)
        tbl[7] = '{32'h0080006F, 32'h58, 5'd0,  5'd0,  32'h00000008, 6'b010010}; // jal x0,8
        tbl[8] = '{32'h000280E7, 32'h5C, 5'd1,  5'd5,  32'h00000000, 6'b110010}; // jalr x1,0(x5)
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                7'b0010011, 7'b0100011, 7'b1100011, 7'b0110011};

        reset = 1'b1; valid_in = 1'b0; flush = 1'b0; ready_in = 1'b0;
        instr_from_fetch = '0; pc_from_fetch = '0;
        tick(); tick();
        chk("reset_vout", valid_out, 1'b0);
        chk("reset_rdy", ready_to_fetch, 1'b1);
        reset = 1'b0;
        tick();
        chk("idle_vout", valid_out, 1'b0);

        // Each table entry: one-cycle latency, decode check, then dequeued.
        ready_in = 1'b1;
        for (int k = 0; k < 9; k++) begin
            valid_in = 1'b1; instr_from_fetch = tbl[k].instr; pc_from_fetch = tbl[k].pc;
            tick();
            valid_in = 1'b0;
            chk($sformatf("tbl%0d_vout", k), valid_out, 1'b1);
            chk($sformatf("tbl%0d_pc", k), pc_out, tbl[k].pc);
            chk($sformatf("tbl%0d_rd", k), rd, tbl[k].rd);
            chk($sformatf("tbl%0d_rs1", k), rs1, tbl[k].rs1);
            chk($sformatf("tbl%0d_imm", k), imm, tbl[k].imm);
            chk($sformatf("tbl%0d_fl", k), fl_act, tbl[k].fl);
            tick();
            chk($sformatf("tbl%0d_deq", k), valid_out, 1'b0);
            chk($sformatf("tbl%0d_fl0", k), fl_act, 6'd0);
        end

        // Stall with two entries, then drain in order; full+pop must not accept.
        ready_in = 1'b0; valid_in = 1'b1; instr_from_fetch = tbl[0].instr;
        pc_from_fetch = 32'h100; tick();
        chk("stall1_pc", pc_out, 32'h100);
        pc_from_fetch = 32'h104; tick();
        chk("full_rdy", ready_to_fetch, 1'b0);
        chk("full_pc", pc_out, 32'h100);
        pc_from_fetch = 32'h108; tick();
        chk("hold_pc", pc_out, 32'h100);
        chk("hold_imm", imm, 32'h5);
        ready_in = 1'b1; pc_from_fetch = 32'h10C; tick();
        chk("drain1_pc", pc_out, 32'h104);
        chk("drain1_rdy", ready_to_fetch, 1'b1);
        valid_in = 1'b0; tick();
        chk("drain2_vout", valid_out, 1'b0);

        // Flush while full with an incoming word.
        ready_in = 1'b0; valid_in = 1'b1;
        pc_from_fetch = 32'h200; tick();
        pc_from_fetch = 32'h204; tick();
        chk("fl_full", ready_to_fetch, 1'b0);
        flush = 1'b1; pc_from_fetch = 32'h208; tick();
        flush = 1'b0; valid_in = 1'b0;
        chk("fl_vout", valid_out, 1'b0);
        chk("fl_rdy", ready_to_fetch, 1'b1);
        tick();
        chk("fl_drop", valid_out, 1'b0);

        // Reset mid-operation overrides everything at that edge.
        valid_in = 1'b1; pc_from_fetch = 32'h300; tick();
        reset = 1'b1; flush = 1'b1; ready_in = 1'b1; pc_from_fetch = 32'h304; tick();
        reset = 1'b0; flush = 1'b0; valid_in = 1'b0;
        chk("rst_vout", valid_out, 1'b0);
        chk("rst_rdy", ready_to_fetch, 1'b1);
        tick();
        chk("rst_after", valid_out, 1'b0);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [31:0] w;
            r = int'($urandom_range(0, 10));
            w = $urandom();
            if (r < 9) w[6:0] = ops[r];
            instr_from_fetch = w;
            pc_from_fetch    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            tick();
            chk_state($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: T, logic [31:0], instruction/PC word type.
REQ-002 Parameter: DEPTH, 2, instruction buffer entries (fixed at 2; other values not supported).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 instr_from_fetch  input  32  instruction word from fetcher.
REQ-006 pc_from_fetch  input  32  PC of instr_from_fetch.
REQ-007 valid_in  input  1  fetcher presents a valid instruction.
REQ-008 ready_to_fetch  output  1  decode can accept an instruction this cycle.
REQ-009 flush  input  1  branch redirect; discard all buffered instructions.
REQ-010 ready_in  input  1  downstream (rename) accepts the head entry.
REQ-011 valid_out  output  1  decoded head entry is valid.
REQ-012 pc_out  output  32  PC of head entry.
REQ-013 rs1, rs2, rd  output  5 each  register fields, instr[19:15], [24:20], [11:7].
REQ-014 opcode / funct3 / funct7  output  7/3/7  instr[6:0], [14:12], [31:25].
REQ-015 imm  output  32  sign-extended immediate.
REQ-016 reg_write, is_branch, is_load, is_store, alu_src_imm, illegal  output  1 each  control flags.

Function
REQ-017 Transfer in: occurs on a rising edge where valid_in=1, ready_to_fetch=1 and flush=0.
REQ-018 Transfer out: occurs on a rising edge where valid_out=1, ready_in=1 and flush=0.
REQ-019 Buffer: 2-entry FIFO of {instr, pc}, 2-bit count (0..2), 1-bit read/write pointers wrapping 1->0.
REQ-020 ready_to_fetch = (count < 2), a function of registered count only; no combinational path from ready_in.
REQ-021 Full (count=2) with a transfer out: ready_to_fetch stays 0 that cycle; count becomes 1.
REQ-022 Simultaneous transfer in and out at count=1: count stays 1; pointers both advance.
REQ-023 valid_out = (count != 0); all decoded outputs are combinational from the head entry.
REQ-024 Latency: an instruction transferred in at edge N is presented with valid_out=1 in the cycle after edge N (count was 0).
REQ-025 Stall: while ready_in=0, head entry and all decoded outputs hold stable.
REQ-026 Flush: at an edge with flush=1, count and pointers are cleared; any same-edge transfer in or out is ignored.
REQ-027 Opcode classes: LUI 0110111, AUIPC 0010111 (U); JAL 1101111 (J); JALR 1100111, LOAD 0000011, OP-IMM 0010011 (I); STORE 0100011 (S); BRANCH 1100011 (B); OP 0110011 (R, imm=0).
REQ-028 imm: I = sext(instr[31:20]); S = sext({[31:25],[11:7]}); B = sext({[31],[7],[30:25],[11:8],0}); U = {[31:12],12'b0}; J = sext({[31],[19:12],[20],[30:21],0}).
REQ-029 reg_write = 1 for U/J/I/R classes and rd != 0; 0 otherwise.
REQ-030 is_branch = BRANCH, JAL or JALR; is_load = LOAD; is_store = STORE; alu_src_imm = 1 for all non-R, non-BRANCH classes.
REQ-031 Any other opcode: illegal=1, all other flags 0, imm=0; entry still passes through the handshake.
REQ-032 valid_out=0: decoded outputs are don't-care, but flags shall be driven 0.

Reset
REQ-033 At an edge with reset=1: count=0 and pointers=0; the bench checks valid_out=0 and ready_to_fetch=1 after that edge.
REQ-034 Reset overrides flush and both transfers at the same edge; buffer contents need no reset.
REQ-035 Reset mid-operation discards all buffered entries; no entry is output after reset deasserts.

Verification
REQ-036 Reset 2 cycles, valid_in=0 -> valid_out=0, ready_to_fetch=1.
REQ-037 Present 0x00500093 @ pc 0x0, ready_in=1 -> next cycle valid_out=1, rd=1, rs1=0, imm=5, reg_write=1, alu_src_imm=1.
REQ-038 Present 0xFE208EE3 (beq x1,x2,-4) @ 0x40 -> is_branch=1, imm=0xFFFFFFFC, reg_write=0; 0x0020A423 -> is_store=1, imm=8; 0x123452B7 -> rd=5, imm=0x12345000.
REQ-039 ready_in=0, stream two instructions -> count=2, ready_to_fetch=0, head PC held; raise ready_in -> PCs emitted in order, no loss or duplicate.
REQ-040 Buffer full, assert flush 1 cycle with valid_in=1 -> valid_out=0 next cycle, incoming word dropped, ready_to_fetch=1.
REQ-041 Present 0xFFFFFFFF -> illegal=1, all other flags 0, accepted and dequeued normally.
